// File: rtl/logic_unit_pipe_if.sv
// Handshake and data bundle for logic_unit_pipe.
// Optional flag signals exist only when LOGIC_UNIT_FLAGS_EN is defined.
interface logic_unit_pipe_if #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned CNT_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     result;
    logic [CNT_WIDTH-1:0] op_count;
`ifdef LOGIC_UNIT_FLAGS_EN
    logic                 flag_zero;
    logic                 flag_ones;
    logic                 flag_parity;
`endif

    // Producer/consumer side (testbench or surrounding logic)
    modport master (
        output in_valid, op, a, b, out_ready,
`ifdef LOGIC_UNIT_FLAGS_EN
        input  flag_zero, flag_ones, flag_parity,
`endif
        input  in_ready, out_valid, result, op_count
    );

    // Logic unit side
    modport slave (
        input  in_valid, op, a, b, out_ready,
`ifdef LOGIC_UNIT_FLAGS_EN
        output flag_zero, flag_ones, flag_parity,
`endif
        output in_ready, out_valid, result, op_count
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with a completed-transfer counter.
// S1 holds the computed result of the accepted operands, S2 is the output register.
// Optional: define LOGIC_UNIT_FLAGS_EN to add zero/ones/parity flags aligned with result.
module logic_unit_pipe #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned CNT_WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    logic_unit_pipe_if.slave  bus
);

    logic                 s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]     s1_data_q, s1_data_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]     s2_data_q, s2_data_d;
    logic [CNT_WIDTH-1:0] op_count_q, op_count_d;
    logic [WIDTH-1:0]     alu_res;
    logic                 s2_load;
    logic                 in_fire;
    logic                 out_fire;

    // Bitwise operation selected by op
    always_comb begin
        alu_res = '0;
        case (bus.op)
            3'b000:  alu_res = bus.a & bus.b;
            3'b001:  alu_res = bus.a | bus.b;
            3'b010:  alu_res = bus.a ^ bus.b;
            3'b011:  alu_res = ~(bus.a ^ bus.b);
            3'b100:  alu_res = ~(bus.a & bus.b);
            3'b101:  alu_res = ~(bus.a | bus.b);
            3'b110:  alu_res = ~bus.a;
            default: alu_res = bus.a;
        endcase
    end

    // Handshake decode and next-state for both stages and the counter
    always_comb begin
        out_fire   = s2_valid_q && bus.out_ready;
        // S1 may advance when S2 is empty or being drained this cycle
        s2_load    = s1_valid_q && (!s2_valid_q || bus.out_ready);
        in_fire    = bus.in_valid && (!s1_valid_q || s2_load);

        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_data_d  = alu_res;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_data_d  = s1_data_q;
        end else if (out_fire) begin
            s2_valid_d = 1'b0;
        end

        op_count_d = op_count_q;
        if (out_fire) begin
            op_count_d = op_count_q + CNT_WIDTH'(1);
        end
    end

    // Pipeline and counter state, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            op_count_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            op_count_q <= op_count_d;
        end
    end

`ifdef LOGIC_UNIT_FLAGS_EN
    logic flag_zero_q, flag_zero_d;
    logic flag_ones_q, flag_ones_d;
    logic flag_parity_q, flag_parity_d;

    // Flags are computed from S1 data so they land together with result
    always_comb begin
        flag_zero_d   = flag_zero_q;
        flag_ones_d   = flag_ones_q;
        flag_parity_d = flag_parity_q;
        if (s2_load) begin
            flag_zero_d   = (s1_data_q == '0);
            flag_ones_d   = (s1_data_q == '1);
            flag_parity_d = ^s1_data_q;
        end
    end

    // Flag registers share the S2 reset and load timing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_zero_q   <= 1'b0;
            flag_ones_q   <= 1'b0;
            flag_parity_q <= 1'b0;
        end else begin
            flag_zero_q   <= flag_zero_d;
            flag_ones_q   <= flag_ones_d;
            flag_parity_q <= flag_parity_d;
        end
    end

    assign bus.flag_zero   = flag_zero_q;
    assign bus.flag_ones   = flag_ones_q;
    assign bus.flag_parity = flag_parity_q;
`endif

    assign bus.in_ready  = !s1_valid_q || s2_load;
    assign bus.out_valid = s2_valid_q;
    assign bus.result    = s2_data_q;
    assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomized self-checking bench for logic_unit_pipe against a queue-based reference.
// Flag checks are compiled in when LOGIC_UNIT_FLAGS_EN is defined.
module tb_logic_unit_pipe;
    localparam int unsigned W  = 4;
    localparam int unsigned CW = 2;

    logic clk;
    logic rst;

    logic_unit_pipe_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();

    logic_unit_pipe #(.WIDTH(W), .CNT_WIDTH(CW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int cnt      = 0;
    logic [W-1:0] exp_q[$];
    int           acc_cyc_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
        case (o)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return x ^ y;
            3'd3:    return ~(x ^ y);
            3'd4:    return ~(x & y);
            3'd5:    return ~(x | y);
            3'd6:    return ~x;
            default: return x;
        endcase
    endfunction

    // One clock cycle: drive, sample before the rising edge, check, update the model
    task automatic step(input logic iv, input logic [2:0] o, input logic [W-1:0] aa,
                        input logic [W-1:0] bb, input logic ordy, output logic acc);
        logic exp_ov;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.op        = o;
        bus.a         = aa;
        bus.b         = bb;
        bus.out_ready = ordy;
        #1;
        // Oldest result is visible once it has been held two cycles since its accept
        exp_ov = (exp_q.size() > 0) && (cyc - acc_cyc_q[0] >= 2);
        check_eq("out_valid", bus.out_valid, exp_ov);
        check_eq("op_count", bus.op_count, cnt);
        if (exp_q.size() == 0)
            check_eq("in_ready_empty", bus.in_ready, 1);
        if (ordy)
            check_eq("in_ready_no_bubble", bus.in_ready, 1);
        if (exp_q.size() == 2 && !ordy)
            check_eq("in_ready_full", bus.in_ready, 0);
        if (bus.out_valid && exp_q.size() > 0) begin
            check_eq("result", bus.result, exp_q[0]);
`ifdef LOGIC_UNIT_FLAGS_EN
            check_eq("flag_zero", bus.flag_zero, exp_q[0] == '0);
            check_eq("flag_ones", bus.flag_ones, exp_q[0] == '1);
            check_eq("flag_parity", bus.flag_parity, ^exp_q[0]);
`endif
            if (ordy) begin
                void'(exp_q.pop_front());
                void'(acc_cyc_q.pop_front());
                cnt = (cnt + 1) % (1 << CW);
            end
        end
        acc = iv && bus.in_ready;
        if (acc) begin
            exp_q.push_back(ref_op(o, aa, bb));
            acc_cyc_q.push_back(cyc);
        end
        cyc++;
    endtask

    logic         acc;
    logic         pend;
    logic [2:0]   r_op;
    logic [W-1:0] r_a, r_b;
    logic [2:0]   ops31 [4];
    logic [W-1:0] bp_a [3];

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = 3'd0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        #1;
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_result", bus.result, 0);
        check_eq("rst_op_count", bus.op_count, 0);
        check_eq("rst_in_ready", bus.in_ready, 1);
`ifdef LOGIC_UNIT_FLAGS_EN
        check_eq("rst_flags", {bus.flag_zero, bus.flag_ones, bus.flag_parity}, 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // XNOR of equal operands, then let it drain
        step(1'b1, 3'b011, 4'b1010, 4'b1010, 1'b1, acc);
        check_eq("req030_accept", acc, 1);
        for (int i = 0; i < 3; i++) step(1'b0, 3'b0, '0, '0, 1'b1, acc);
        check_eq("req030_op_count", bus.op_count, 1);

        // Back-to-back ops on the same operands
        ops31[0] = 3'b011; ops31[1] = 3'b000; ops31[2] = 3'b010; ops31[3] = 3'b101;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, ops31[i], 4'b0111, 4'b1001, 1'b1, acc);
            check_eq("req031_accept", acc, 1);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 3'b0, '0, '0, 1'b1, acc);

        // Backpressure: three sets offered while the consumer stalls
        bp_a[0] = 4'h3; bp_a[1] = 4'hC; bp_a[2] = 4'h5;
        begin
            int k = 0;
            for (int i = 0; i < 6; i++) begin
                step(k < 3, 3'b111, bp_a[k % 3], '0, 1'b0, acc);
                if (acc) k++;
            end
            check_eq("req032_buffered", k, 2);
            for (int i = 0; i < 12 && (k < 3 || exp_q.size() > 0); i++) begin
                step(k < 3, 3'b111, bp_a[k % 3], '0, 1'b1, acc);
                if (acc) k++;
            end
            check_eq("req032_all_accepted", k, 3);
            check_eq("req032_drained", exp_q.size(), 0);
        end

`ifdef LOGIC_UNIT_FLAGS_EN
        step(1'b1, 3'b111, 4'h0, '0, 1'b1, acc);
        step(1'b1, 3'b111, 4'hF, '0, 1'b1, acc);
        step(1'b1, 3'b111, 4'h7, '0, 1'b1, acc);
        for (int i = 0; i < 3; i++) step(1'b0, 3'b0, '0, '0, 1'b1, acc);
`endif

        // Reset with two results in flight
        step(1'b1, 3'b001, 4'h9, 4'h2, 1'b0, acc);
        step(1'b1, 3'b100, 4'h6, 4'h3, 1'b0, acc);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("req034_out_valid", bus.out_valid, 0);
        check_eq("req034_op_count", bus.op_count, 0);
        check_eq("req034_in_ready", bus.in_ready, 1);
        exp_q.delete();
        acc_cyc_q.delete();
        cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 3'b0, '0, '0, 1'b1, acc);

        // Random traffic; producer holds its data until accepted
        pend = 1'b0;
        r_op = '0;
        r_a  = '0;
        r_b  = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pend) begin
                pend = ($urandom_range(0, 3) != 0);
                r_op = 3'($urandom_range(0, 7));
                r_a  = W'($urandom);
                r_b  = W'($urandom);
            end
            step(pend, r_op, r_a, r_b, $urandom_range(0, 3) != 0, acc);
            if (acc) pend = 1'b0;
        end
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) step(1'b0, 3'b0, '0, '0, 1'b1, acc);
        check_eq("final_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 Parameter WIDTH, default 4: operand and result width in bits, legal range 1..64.
REQ-002 Parameter CNT_WIDTH, default 8: width of the completed-operation counter, legal range 2..32.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous reset, active-high.
REQ-005 in_valid  input  1  operand set and op code presented.
REQ-006 in_ready  output  1  unit accepts the operand set this cycle.
REQ-007 op  input  3  operation select, encoded per REQ-014.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 out_valid  output  1  result holds valid data.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 result  output  WIDTH  bitwise result.
REQ-013 op_count  output  CNT_WIDTH  number of completed output transfers, modulo 2^CNT_WIDTH.

Function
REQ-014 op encoding: 000 AND, 001 OR, 010 XOR, 011 XNOR, 100 NAND, 101 NOR, 110 NOT a (b ignored), 111 PASS a (b ignored).
REQ-015 Input transfer occurs when in_valid && in_ready on a rising edge; output transfer occurs when out_valid && out_ready on a rising edge.
REQ-016 Two-stage pipeline: S1 registers the computed result of the accepted operands; S2 is the output register driving result and out_valid.
REQ-017 Latency: out_valid rises exactly 2 cycles after the input-transfer edge, provided S2 is empty or draining.
REQ-018 S2 loads from S1 when S1 is valid and (S2 is empty or an output transfer occurs this cycle).
REQ-019 in_ready = !S1_valid || (S1 loads into S2 this cycle); in_ready has no combinational dependence on in_valid.
REQ-020 With out_ready held high, the unit sustains one transfer per cycle with no bubbles.
REQ-021 While out_valid=1 and out_ready=0, result and out_valid hold stable and no operand set is lost or duplicated; at most 2 operand sets are buffered.
REQ-022 Results emerge strictly in acceptance order.
REQ-023 op_count increments by 1 on every output transfer and wraps from 2^CNT_WIDTH-1 to 0.
REQ-024 in_valid with in_ready=0 has no effect; the producer holds its data.

Reset
REQ-025 When rst is asserted, S1_valid, S2_valid, out_valid, result and op_count clear to 0 immediately, independent of clk.
REQ-026 in_ready reads 1 while rst is high and on the first cycle after release.
REQ-027 Reset asserted mid-operation discards all in-flight results without producing an output transfer.

Configuration
REQ-028 Macro LOGIC_UNIT_FLAGS_EN, when defined, adds outputs flag_zero, flag_ones and flag_parity (1 bit each), registered in step with result: result==0, result==all ones, and XOR-reduction of result, respectively; all three reset to 0.
REQ-029 Without LOGIC_UNIT_FLAGS_EN, the flag ports and their registers are absent; all other behaviour is identical.

Verification
REQ-030 WIDTH=4: a=1010, b=1010, op=011, out_ready=1 -> result=1111 two cycles after accept; op_count=1.
REQ-031 WIDTH=4: a=0111, b=1001, issued back-to-back with op=011, 000, 010, 101 -> results 0001, 0001, 1110, 0000 on consecutive cycles, in order.
REQ-032 Backpressure: out_ready=0 with 3 operand sets offered -> first 2 accepted, in_ready=0 afterwards, result held; out_ready=1 -> all 3 results drain in order with none lost.
REQ-033 CNT_WIDTH=2: 5 output transfers -> op_count sequence 1, 2, 3, 0, 1.
REQ-034 rst asserted with 2 results in flight -> out_valid=0 and op_count=0 immediately; no stale result appears after release.
REQ-035 With LOGIC_UNIT_FLAGS_EN, WIDTH=8: op=111, a=0x00 -> flag_zero=1; a=0xFF -> flag_ones=1 and flag_parity=0; a=0x07 -> flag_parity=1.
